// File: rtl/complex_result_writer.sv
// complex_result_writer
// Captures LANES pairs of 8-bit real/imag ALU results on a load strobe and
// writes them, one lane per cycle, as packed 18-bit complex words into an
// internal result RAM. A registered read port returns RAM words in the same
// 18-bit format.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   load       batch start strobe, honoured only in IDLE
//   in_r       lane k real result at [8k+7:8k]
//   in_i       lane k imaginary result at [8k+7:8k]
//   base_addr  RAM address of lane 0, sampled with load
//   rd_addr    read address
//   rd_data    RAM[rd_addr], one cycle latency, read-before-write
//   busy       high while lane writes are in progress
//   done       one-cycle pulse after the last lane is written
//   wr_count   completed batches since reset, wraps
module complex_result_writer #(
  parameter int unsigned LANES = 4,
  parameter int unsigned AW    = 5,
  parameter int unsigned DEPTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [LANES*8-1:0]   in_r,
  input  logic [LANES*8-1:0]   in_i,
  input  logic [AW-1:0]        base_addr,
  input  logic [AW-1:0]        rd_addr,
  output logic [17:0]          rd_data,
  output logic                 busy,
  output logic                 done,
  output logic [7:0]           wr_count
);

  localparam int unsigned IW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned WW = 18;

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t          state_q;
  logic [IW-1:0]   idx_q;
  logic [AW-1:0]   base_q;
  logic [7:0]      cap_r_q [LANES];
  logic [7:0]      cap_i_q [LANES];

  logic [WW-1:0]   mem [DEPTH];

  logic            we_c;
  logic [AW-1:0]   waddr_c;
  logic [WW-1:0]   wdata_c;

  // Write port: current lane, sign-extended to 9+9 bits; address wraps mod DEPTH.
  always_comb begin
    we_c    = (state_q == WRITE);
    waddr_c = base_q + AW'(idx_q);
    wdata_c = {cap_r_q[idx_q][7], cap_r_q[idx_q], cap_i_q[idx_q][7], cap_i_q[idx_q]};
  end

  // Batch sequencer with registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      base_q   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      wr_count <= '0;
      for (int unsigned k = 0; k < LANES; k++) begin
        cap_r_q[k] <= '0;
        cap_i_q[k] <= '0;
      end
    end else begin
      done <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (load) begin
            for (int unsigned k = 0; k < LANES; k++) begin
              cap_r_q[k] <= in_r[8*k +: 8];
              cap_i_q[k] <= in_i[8*k +: 8];
            end
            base_q  <= base_addr;
            idx_q   <= '0;
            busy    <= 1'b1;
            state_q <= WRITE;
          end
        end
        WRITE: begin
          idx_q <= idx_q + IW'(1);
          if (idx_q == IW'(LANES - 1)) begin
            busy    <= 1'b0;
            state_q <= DONE;
          end
        end
        DONE: begin
          done     <= 1'b1;
          wr_count <= wr_count + 8'd1;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Result RAM storage; contents deliberately not reset.
  always_ff @(posedge clk) begin
    if (we_c) begin
      mem[waddr_c] <= wdata_c;
    end
  end

  // Registered read port; non-blocking update gives read-before-write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: tb/tb_complex_result_writer.sv
// Directed bench for complex_result_writer: a shadow RAM model plus a
// scoreboard queue of expected read words, and per-cycle status checks
// around every batch.
module tb_complex_result_writer;

  localparam int unsigned LANES = 4;
  localparam int unsigned AW    = 5;
  localparam int unsigned DEPTH = 32;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                load = 1'b0;
  logic [LANES*8-1:0]  in_r = '0;
  logic [LANES*8-1:0]  in_i = '0;
  logic [AW-1:0]       base_addr = '0;
  logic [AW-1:0]       rd_addr = '0;
  logic [17:0]         rd_data;
  logic                busy;
  logic                done;
  logic [7:0]          wr_count;

  int checks = 0;
  int failures = 0;
  logic [7:0]  exp_wr = 8'd0;
  logic [17:0] model [DEPTH];
  logic [17:0] sb_q [$];

  always #5 clk = ~clk;

  complex_result_writer #(.LANES(LANES), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .in_r(in_r), .in_i(in_i),
    .base_addr(base_addr), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done), .wr_count(wr_count)
  );

  function automatic logic [17:0] pack(input logic [7:0] r, input logic [7:0] i);
    return {r[7], r, i[7], i};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present an address, queue the expected word, compare one cycle later.
  task automatic read_check(input logic [AW-1:0] addr, input logic [17:0] exp);
    logic [17:0] e;
    @(negedge clk);
    rd_addr = addr;
    sb_q.push_back(exp);
    @(negedge clk);
    e = sb_q.pop_front();
    check($sformatf("rd[%0d]", addr), 32'(rd_data), 32'(e));
  endtask

  // One batch from the load strobe to well past the done pulse.
  // ign: a second load with other data two cycles into WRITE.
  // rst_mid: assert reset once lane 1 is written.
  // coll: hold rd_addr on lane 2's address during the batch.
  task automatic run_batch(input logic [AW-1:0] base, input logic [31:0] rv,
                           input logic [31:0] iv, input bit ign,
                           input bit rst_mid, input bit coll);
    logic [17:0] old2;
    logic [17:0] new2;
    logic [AW-1:0] a;
    old2 = model[base + AW'(2)];
    new2 = pack(rv[23:16], iv[23:16]);
    @(negedge clk);
    in_r = rv; in_i = iv; base_addr = base; load = 1'b1;
    if (coll) rd_addr = base + AW'(2);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      load = 1'b0;
      check($sformatf("busy@%0d", c), 32'(busy), 32'(c < 4));
      check($sformatf("done@%0d", c), 32'(done), 32'(c == 5));
      if (c == 5) exp_wr = exp_wr + 8'd1;
      check($sformatf("wr_count@%0d", c), 32'(wr_count), 32'(exp_wr));
      if (coll && c == 3) check("coll_old", 32'(rd_data), 32'(old2));
      if (coll && c == 4) check("coll_new", 32'(rd_data), 32'(new2));
      if (ign && c == 1) begin
        load = 1'b1; in_r = ~rv; in_i = rv; base_addr = base + AW'(1);
      end
      if (rst_mid && c == 2) begin
        rst_n = 1'b0;
        #1;
        exp_wr = 8'd0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_wr_count", 32'(wr_count), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        for (int k = 0; k < 2; k++) begin
          a = base + AW'(k);
          model[a] = pack(rv[8*k +: 8], iv[8*k +: 8]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
    end
    for (int k = 0; k < LANES; k++) begin
      a = base + AW'(k);
      model[a] = pack(rv[8*k +: 8], iv[8*k +: 8]);
    end
  endtask

  initial begin
    for (int k = 0; k < DEPTH; k++) model[k] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_wr_count", 32'(wr_count), 32'd0);
    check("reset_rd_data", 32'(rd_data), 32'd0);
    rst_n = 1'b1;

    // Basic batch; lane 0 = 0x01/0xFF
    run_batch(5'd0, 32'h04030201, 32'h807F00FF, 1'b0, 1'b0, 1'b0);
    read_check(5'd0, 18'h003FF);
    read_check(5'd1, 18'h00400);
    read_check(5'd2, 18'h0067F);
    read_check(5'd3, 18'h00980);

    // Sign extension extremes
    run_batch(5'd4, 32'h80808080, 32'h80808080, 1'b0, 1'b0, 1'b0);
    for (int k = 4; k < 8; k++) read_check(AW'(k), 18'h30180);
    run_batch(5'd8, 32'h7F7F7F7F, 32'h7F7F7F7F, 1'b0, 1'b0, 1'b0);
    for (int k = 8; k < 12; k++) read_check(AW'(k), 18'h0FE7F);

    // Fill the rest, then a wrapping batch at 30 -> 30,31,0,1
    for (int b = 12; b < 32; b += 4) begin
      run_batch(AW'(b), $urandom, $urandom, 1'b0, 1'b0, 1'b0);
    end
    run_batch(5'd30, 32'hA55A0FF0, 32'h12EDC381, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < DEPTH; k++) read_check(AW'(k), model[k]);

    // Load during WRITE is ignored
    run_batch(5'd12, 32'h11223344, 32'h99AABBCC, 1'b1, 1'b0, 1'b0);
    for (int k = 12; k < 17; k++) read_check(AW'(k), model[k]);

    // Same-address read during write returns old then new
    run_batch(5'd20, 32'h5060708F, 32'hF1E2D3C4, 1'b0, 1'b0, 1'b1);
    for (int k = 20; k < 24; k++) read_check(AW'(k), model[k]);

    // Reset after lane 1: lanes 2..3 keep old contents
    run_batch(5'd24, 32'hDEADBEEF, 32'h01234567, 1'b0, 1'b1, 1'b0);
    for (int k = 24; k < 28; k++) read_check(AW'(k), model[k]);

    // First batch after reset release
    run_batch(5'd0, 32'h0A0B0C0D, 32'hF0F1F2F3, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) read_check(AW'(k), model[k]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the bench always terminates.
  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
